// File: rtl/sync_pkg.sv
// Shared constants and helpers for the pointer/flush clock-domain-crossing synchronisers.
package sync_pkg;

  localparam int SYNC_MIN_STAGES = 2;
  localparam int SYNC_MAX_STAGES = 4;
  localparam int SYNC_PTR_MAX_W  = 32;

  typedef logic [SYNC_PTR_MAX_W-1:0] sync_word_t;

  // Zero-extended Gray converts to the zero-extended binary, so one wide function serves every width.
  function automatic sync_word_t gray2bin(input sync_word_t g);
    sync_word_t b;
    b = '0;
    b[SYNC_PTR_MAX_W-1] = g[SYNC_PTR_MAX_W-1];
    for (int i = SYNC_PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic multi_bit_change(input sync_word_t a, input sync_word_t b);
    return $countones(a ^ b) > 1;
  endfunction

endpackage

// File: rtl/sync_cell.sv
// Plain N-flop vector synchroniser with asynchronous active-high reset.
module sync_cell
  import sync_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_out,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES < SYNC_MIN_STAGES || STAGES > SYNC_MAX_STAGES) begin : g_bad_stages
    $error("sync_cell: STAGES=%0d outside %0d..%0d", STAGES, SYNC_MIN_STAGES, SYNC_MAX_STAGES);
  end

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/ptr_sync_gen.sv
// Brings a Gray FIFO pointer and a flush level into clk_out, adding binary conversion,
// an update strobe, a flush pulse and an armed Gray-step integrity checker.
module ptr_sync_gen
  import sync_pkg::*;
#(
  parameter int DEPTH       = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk_out,
  input  logic           reset,
  input  logic [DEPTH:0] ptr_gray_in,
  input  logic           flush,
  input  logic           err_clr,
  output logic [DEPTH:0] ptr_gray_out,
  output logic [DEPTH:0] ptr_bin_out,
  output logic           ptr_upd,
  output logic           flush_out,
  output logic           flush_pulse,
  output logic           gray_err,
  output logic           chk_armed
);

  localparam int PW        = DEPTH + 1;
  localparam int ARM_COUNT = SYNC_STAGES + 2;

  if (DEPTH < 1 || PW > SYNC_PTR_MAX_W) begin : g_bad_depth
    $error("ptr_sync_gen: DEPTH=%0d unsupported", DEPTH);
  end

  logic [PW-1:0] ptr_sync;
  logic          flush_sync;
  logic          flush_out_q;
  logic [2:0]    arm_cnt;
  logic          ptr_change;
  logic          ptr_bad_step;

  sync_cell #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_ptr_sync (
    .clk_out (clk_out),
    .reset   (reset),
    .d       (ptr_gray_in),
    .q       (ptr_sync)
  );

  sync_cell #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_flush_sync (
    .clk_out (clk_out),
    .reset   (reset),
    .d       (flush),
    .q       (flush_sync)
  );

  assign flush_out    = flush_sync;
  assign ptr_change   = (ptr_sync != ptr_gray_out);
  assign ptr_bad_step = multi_bit_change(SYNC_PTR_MAX_W'(ptr_sync), SYNC_PTR_MAX_W'(ptr_gray_out));

  // Output stage: binary is derived from the same synchroniser value so both outputs stay coherent.
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      ptr_gray_out <= '0;
      ptr_bin_out  <= '0;
      ptr_upd      <= 1'b0;
      flush_out_q  <= 1'b0;
      flush_pulse  <= 1'b0;
      gray_err     <= 1'b0;
    end else begin
      ptr_gray_out <= ptr_sync;
      ptr_bin_out  <= PW'(gray2bin(SYNC_PTR_MAX_W'(ptr_sync)));
      ptr_upd      <= ptr_change;
      flush_out_q  <= flush_sync;
      flush_pulse  <= flush_sync & ~flush_out_q;
      gray_err     <= (chk_armed & ptr_bad_step) | (gray_err & ~err_clr);
    end
  end

  // Hold the checker off until whatever the source held at reset release has crossed.
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      arm_cnt   <= '0;
      chk_armed <= 1'b0;
    end else if (!chk_armed) begin
      arm_cnt <= arm_cnt + 3'd1;
      if (arm_cnt == 3'(ARM_COUNT - 1)) chk_armed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ptr_sync_gen.sv
// Directed self-checking bench for ptr_sync_gen at SYNC_STAGES=2 and SYNC_STAGES=4.
module tb_ptr_sync_gen;

  logic       clk_out = 1'b0;
  logic       reset;
  logic [7:0] ptr_gray_in;
  logic       flush;
  logic       err_clr;

  logic [7:0] p_gray, p_bin, p_gray4, p_bin4;
  logic       p_upd, f_out, f_pulse, g_err, armed;
  logic       p_upd4, f_out4, f_pulse4, g_err4, armed4;

  int errors = 0;
  int checks = 0;

  always #5 clk_out = ~clk_out;

  ptr_sync_gen #(.DEPTH(7), .SYNC_STAGES(2)) dut (
    .clk_out      (clk_out),
    .reset        (reset),
    .ptr_gray_in  (ptr_gray_in),
    .flush        (flush),
    .err_clr      (err_clr),
    .ptr_gray_out (p_gray),
    .ptr_bin_out  (p_bin),
    .ptr_upd      (p_upd),
    .flush_out    (f_out),
    .flush_pulse  (f_pulse),
    .gray_err     (g_err),
    .chk_armed    (armed)
  );

  ptr_sync_gen #(.DEPTH(7), .SYNC_STAGES(4)) dut4 (
    .clk_out      (clk_out),
    .reset        (reset),
    .ptr_gray_in  (ptr_gray_in),
    .flush        (flush),
    .err_clr      (err_clr),
    .ptr_gray_out (p_gray4),
    .ptr_bin_out  (p_bin4),
    .ptr_upd      (p_upd4),
    .flush_out    (f_out4),
    .flush_pulse  (f_pulse4),
    .gray_err     (g_err4),
    .chk_armed    (armed4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_out);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] ptr, input logic fl, input logic clr);
    ptr_gray_in = ptr;
    flush       = fl;
    err_clr     = clr;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(8'h5A, 1'b0, 1'b0);
    tick(2);
    checkOutput("rst_gray", p_gray, 0);
    checkOutput("rst_bin", p_bin, 0);
    checkOutput("rst_upd", p_upd, 0);
    checkOutput("rst_fout", f_out, 0);
    checkOutput("rst_fpulse", f_pulse, 0);
    checkOutput("rst_err", g_err, 0);
    checkOutput("rst_armed", armed, 0);
    checkOutput("rst_armed4", armed4, 0);

    // Source already at 0x5A when reset releases.
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      checkOutput($sformatf("arm_k%0d", k), armed, (k >= 4) ? 1 : 0);
      checkOutput($sformatf("arm4_k%0d", k), armed4, (k >= 6) ? 1 : 0);
      if (k == 2) checkOutput("arm_gray_k2", p_gray, 8'h00);
      if (k == 3) begin
        checkOutput("arm_gray_k3", p_gray, 8'h5A);
        checkOutput("arm_bin_k3", p_bin, 8'h6C);
        checkOutput("arm_upd_k3", p_upd, 1);
      end
      if (k == 4) checkOutput("arm_gray4_k4", p_gray4, 8'h00);
      if (k == 5) checkOutput("arm_gray4_k5", p_gray4, 8'h5A);
    end
    checkOutput("arm_err", g_err, 0);
    checkOutput("arm_err4", g_err4, 0);

    // Latency from a clean zero state.
    reset = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0);
    tick(1);
    reset = 1'b0;
    tick(8);
    applyStimulus(8'h01, 1'b0, 1'b0);
    tick(2);
    checkOutput("lat_gray_e2", p_gray, 8'h00);
    checkOutput("lat_upd_e2", p_upd, 0);
    tick(1);
    checkOutput("lat_gray_e3", p_gray, 8'h01);
    checkOutput("lat_bin_e3", p_bin, 8'h01);
    checkOutput("lat_upd_e3", p_upd, 1);
    tick(1);
    checkOutput("lat_upd_e4", p_upd, 0);
    checkOutput("lat4_gray_e4", p_gray4, 8'h00);
    tick(1);
    checkOutput("lat4_gray_e5", p_gray4, 8'h01);
    checkOutput("lat4_upd_e5", p_upd4, 1);
    tick(1);
    checkOutput("lat4_upd_e6", p_upd4, 0);

    // Full sweep from binary 2 through 255 and the wrap back to 0.
    for (int i = 2; i <= 256; i++) begin
      logic [7:0] b;
      b = 8'(i);
      applyStimulus(b ^ (b >> 1), 1'b0, 1'b0);
      tick(4);
      checkOutput($sformatf("sweep_bin_%0d", i), p_bin, b);
      checkOutput($sformatf("sweep_err_%0d", i), g_err, 0);
    end
    tick(4);
    checkOutput("sweep_end_gray", p_gray, 8'h00);
    checkOutput("sweep_err4", g_err4, 0);
    checkOutput("sweep_bin4", p_bin4, 8'h00);

    // Illegal two-bit step, sticky hold, then clear.
    applyStimulus(8'h03, 1'b0, 1'b0);
    tick(2);
    checkOutput("int_err_e2", g_err, 0);
    tick(1);
    checkOutput("int_upd_e3", p_upd, 1);
    checkOutput("int_err_e3", g_err, 1);
    tick(2);
    checkOutput("int_err_sticky", g_err, 1);
    checkOutput("int_err4", g_err4, 1);
    applyStimulus(8'h03, 1'b0, 1'b1);
    tick(1);
    checkOutput("int_clr", g_err, 0);
    checkOutput("int_clr4", g_err4, 0);

    // Illegal step back to 0 while the clear is held: set wins, then clear takes over.
    applyStimulus(8'h00, 1'b0, 1'b1);
    tick(3);
    checkOutput("int_setwins", g_err, 1);
    tick(1);
    checkOutput("int_held_clr", g_err, 0);
    tick(1);
    checkOutput("int_setwins4", g_err4, 1);
    applyStimulus(8'h00, 1'b0, 1'b0);
    tick(2);

    // Flush held for 10 cycles, with a legal pointer step on the same cycle.
    applyStimulus(8'h01, 1'b1, 1'b0);
    tick(1);
    checkOutput("fl_out_e1", f_out, 0);
    tick(1);
    checkOutput("fl_out_e2", f_out, 1);
    checkOutput("fl_pulse_e2", f_pulse, 0);
    tick(1);
    checkOutput("fl_pulse_e3", f_pulse, 1);
    checkOutput("fl_upd_e3", p_upd, 1);
    tick(1);
    checkOutput("fl_pulse_e4", f_pulse, 0);
    tick(1);
    checkOutput("fl_pulse4_e5", f_pulse4, 1);
    for (int k = 6; k <= 10; k++) begin
      tick(1);
      checkOutput($sformatf("fl_nopulse_e%0d", k), f_pulse, 0);
    end
    applyStimulus(8'h01, 1'b0, 1'b0);
    tick(1);
    checkOutput("fl_fall_e1", f_out, 1);
    tick(1);
    checkOutput("fl_fall_e2", f_out, 0);
    tick(1);
    checkOutput("fl_fall_pulse", f_pulse, 0);

    // Reset asserted while a flush pulse is high.
    applyStimulus(8'h01, 1'b1, 1'b0);
    tick(3);
    checkOutput("mid_pulse", f_pulse, 1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_fout", f_out, 0);
    checkOutput("mid_rst_fpulse", f_pulse, 0);
    checkOutput("mid_rst_gray", p_gray, 0);
    checkOutput("mid_rst_err", g_err, 0);
    checkOutput("mid_rst_armed", armed, 0);
    tick(2);
    applyStimulus(8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      checkOutput($sformatf("rel_pulse_%0d", k), f_pulse, 0);
      checkOutput($sformatf("rel_upd_%0d", k), p_upd, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
